// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader uses the slave modport; the byte source and memory side use master.
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses A5 | N(16b LE) | 4N data bytes | XOR checksum into imem writes, then releases the core.
// Writes land one cycle after a word's 4th byte; never stalls the stream (rx_ready drops only on load_req or RUN/ERROR).
module prog_loader #(
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_req,
  prog_loader_if.slave bus,
  output logic         core_rst_n,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  typedef enum logic [2:0] {
    SYNC, LEN_LO, LEN_HI, DATA, CSUM, RUN, ERROR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              rdy;
  logic              accept;
  logic [7:0]        len_lo;
  logic [7:0]        csum;
  logic [15:0]       len;
  logic              len_bad;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] last_idx;
  logic              word_done;
  logic              last_word;

  assign len       = {bus.rx_data, len_lo};
  assign len_bad   = (len == 16'd0) || ({1'b0, len} > DEPTH_L);
  assign word_done = (byte_cnt == 2'd3);
  assign last_word = word_done && (word_idx == last_idx);
  assign bus.rx_ready = rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    accept    = 1'b0;

    case (state)
      SYNC, LEN_LO, LEN_HI, DATA, CSUM: begin
        busy = 1'b1;
        rdy  = !load_req;
      end
      RUN:     done = 1'b1;
      ERROR:   err  = 1'b1;
      default: ;
    endcase

    accept = bus.rx_valid && rdy;

    case (state)
      SYNC:    if (accept && bus.rx_data == 8'hA5) state_nxt = LEN_LO;
      LEN_LO:  if (accept) state_nxt = LEN_HI;
      LEN_HI:  if (accept) state_nxt = len_bad ? ERROR : DATA;
      DATA:    if (accept && last_word) state_nxt = CSUM;
      CSUM:    if (accept) state_nxt = (bus.rx_data == csum) ? RUN : ERROR;
      RUN:     state_nxt = RUN;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = SYNC;
    endcase

    // load_req overrides whatever the frame parser decided this cycle
    if (load_req) state_nxt = SYNC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      core_rst_n     <= 1'b0;
      len_lo         <= '0;
      csum           <= '0;
      byte_cnt       <= '0;
      word_buf       <= '0;
      word_idx       <= '0;
      last_idx       <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      core_rst_n  <= (state == RUN) && !load_req;

      if (accept) begin
        case (state)
          LEN_LO: len_lo <= bus.rx_data;
          LEN_HI: begin
            word_idx <= '0;
            csum     <= '0;
            byte_cnt <= '0;
            last_idx <= ADDR_W'(len - 16'd1);
          end
          DATA: begin
            csum     <= csum ^ bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= bus.rx_data;
              2'd1: word_buf[15:8]  <= bus.rx_data;
              2'd2: word_buf[23:16] <= bus.rx_data;
              default: begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= word_idx;
                bus.imem_wdata <= {bus.rx_data, word_buf};
                // holding on the last word keeps the index inside the memory
                if (!last_word) word_idx <= word_idx + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // a word needs four byte cycles, so write strobes can never be adjacent
  assert property (@(posedge clk) disable iff (rst) bus.imem_we |=> !bus.imem_we);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: byte-position reference model checked every cycle, plus directed frames and randomized traffic.
module tb_prog_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [7:0] byte_q_t[$];

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic load_req = 1'b0;
  logic core_rst_n;
  logic busy;
  logic done;
  logic err;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam int M_HUNT = 0, M_FRAME = 1, M_RUN = 2, M_ERR = 3;
  int          mode     = M_HUNT;
  int          pos      = 0;
  int          n_words  = 0;
  logic [7:0]  n_lo     = '0;
  logic [7:0]  m_csum   = '0;
  logic [31:0] m_word   = '0;
  logic        exp_we   = 1'b0;
  int          exp_addr = 0;
  logic [31:0] exp_data = '0;
  logic        exp_core = 1'b0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] dut_mem   [DEPTH];
  int          wr_cnt    = 0;
  int          last_addr = 0;
  logic        chk_en    = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame semantics by byte position: 0 = sync, 1..2 = length, 3..3+4N-1 = data, then checksum.
  function automatic void model_step();
    int k;
    exp_we = 1'b0;
    if (rst) begin
      mode = M_HUNT; pos = 0; exp_core = 1'b0; exp_addr = 0; exp_data = '0;
      return;
    end
    exp_core = (mode == M_RUN) && !load_req;
    if (load_req) begin
      mode = M_HUNT;
      return;
    end
    if (!bus.rx_valid || !(mode == M_HUNT || mode == M_FRAME)) return;
    if (mode == M_HUNT) begin
      if (bus.rx_data == 8'hA5) begin
        mode = M_FRAME;
        pos  = 1;
      end
      return;
    end
    if (pos == 1) begin
      n_lo = bus.rx_data;
    end else if (pos == 2) begin
      n_words = int'({bus.rx_data, n_lo});
      if (n_words == 0 || n_words > DEPTH) mode = M_ERR;
      m_csum = '0;
    end else if (pos < 3 + 4 * n_words) begin
      k = pos - 3;
      m_word[8 * (k % 4) +: 8] = bus.rx_data;
      m_csum = m_csum ^ bus.rx_data;
      if (k % 4 == 3) begin
        exp_we   = 1'b1;
        exp_addr = k / 4;
        exp_data = m_word;
        model_mem[k / 4] = m_word;
      end
    end else begin
      mode = (bus.rx_data == m_csum) ? M_RUN : M_ERR;
    end
    pos++;
  endfunction

  initial forever begin
    @(negedge clk);
    if (bus.imem_we === 1'b1) begin
      dut_mem[bus.imem_addr] = bus.imem_wdata;
      wr_cnt++;
      last_addr = int'(bus.imem_addr);
    end
    if (chk_en) begin
      chk1("rx_ready", bus.rx_ready, (mode == M_HUNT || mode == M_FRAME) && !load_req);
      chk1("busy", busy, mode == M_HUNT || mode == M_FRAME);
      chk1("done", done, mode == M_RUN);
      chk1("err", err, mode == M_ERR);
      chk1("core_rst_n", core_rst_n, exp_core);
      chk1("imem_we", bus.imem_we, exp_we);
      if (exp_we) begin
        chk32("imem_addr", 32'(bus.imem_addr), 32'(exp_addr));
        chk32("imem_wdata", bus.imem_wdata, exp_data);
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic lr);
    bus.rx_valid = v;
    bus.rx_data  = d;
    load_req     = lr;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic pulse_load();
    cyc(1'b1, 8'hA5, 1'b1);
  endtask

  task automatic send_q(input byte_q_t q, input int gap_max, input int lr_pct);
    foreach (q[i]) begin
      if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
      if (lr_pct > 0 && int'($urandom_range(0, 99)) < lr_pct) pulse_load();
      send(q[i]);
    end
  endtask

  task automatic build_frame(input int n, input logic good, output byte_q_t q);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = '0;
    q = {};
    q.push_back(8'hA5);
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    if (n >= 1 && n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        for (int b = 0; b < 4; b++) begin
          q.push_back(w[8 * b +: 8]);
          cs = cs ^ w[8 * b +: 8];
        end
      end
      q.push_back(good ? cs : ~cs);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    byte_q_t q;
    int      base;
    int      n;

    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    chk_en = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    chk1("rst_core_rst_n", core_rst_n, 1'b0);
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_imem_we", bus.imem_we, 1'b0);
    chk32("rst_imem_addr", 32'(bus.imem_addr), 32'h0);
    chk32("rst_imem_wdata", bus.imem_wdata, 32'h0);
    rst = 1'b0;
    idle(2);

    // reference frame
    base = wr_cnt;
    q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_q(q, 0, 0);
    idle(2);
    chk32("ref_writes", 32'(wr_cnt - base), 32'd2);
    chk32("ref_mem0", dut_mem[0], 32'h0000_0013);
    chk32("ref_mem1", dut_mem[1], 32'h0010_0093);
    chk32("ref_model_mem1", model_mem[1], 32'h0010_0093);
    chk1("ref_done", done, 1'b1);
    chk1("ref_core_rst_n", core_rst_n, 1'b1);

    // bad checksum, then recovery by load_req
    pulse_load();
    q[11] = 8'h91;
    send_q(q, 0, 0);
    idle(2);
    chk1("badcs_err", err, 1'b1);
    chk1("badcs_core_rst_n", core_rst_n, 1'b0);
    pulse_load();
    chk1("badcs_err_cleared", err, 1'b0);
    chk1("badcs_busy", busy, 1'b1);

    // noise before sync
    base = wr_cnt;
    q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_q(q, 2, 0);
    idle(2);
    chk1("noise_done", done, 1'b1);
    chk32("noise_writes", 32'(wr_cnt - base), 32'd2);

    // illegal lengths
    pulse_load();
    base = wr_cnt;
    q = '{8'hA5, 8'h00, 8'h00};
    send_q(q, 0, 0);
    chk1("len0_err", err, 1'b1);
    pulse_load();
    q = '{8'hA5, 8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_q(q, 0, 0);
    idle(1);
    chk1("len257_err", err, 1'b1);
    chk32("badlen_writes", 32'(wr_cnt - base), 32'd0);

    // abort after the 6th data byte, then a fresh frame
    pulse_load();
    base = wr_cnt;
    q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    send_q(q, 0, 0);
    pulse_load();
    idle(2);
    chk32("abort_writes", 32'(wr_cnt - base), 32'd1);
    chk1("abort_core_rst_n", core_rst_n, 1'b0);
    chk1("abort_busy", busy, 1'b1);
    base = wr_cnt;
    build_frame(2, 1'b1, q);
    send_q(q, 1, 0);
    idle(2);
    chk1("fresh_done", done, 1'b1);
    chk32("fresh_writes", 32'(wr_cnt - base), 32'd2);

    // load_req on the same cycle as a pending write
    pulse_load();
    base = wr_cnt;
    q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_q(q, 0, 0);
    pulse_load();
    idle(1);
    chk32("pending_writes", 32'(wr_cnt - base), 32'd1);
    chk32("pending_mem0", dut_mem[0], 32'hDEAD_BEEF);

    // randomized frames, gaps, noise, aborts and bad lengths/checksums
    for (int it = 0; it < 24; it++) begin
      pulse_load();
      case ($urandom_range(0, 7))
        0:       n = (($urandom_range(0, 1) == 0) ? 0 : 257 + int'($urandom_range(0, 40)));
        default: n = int'($urandom_range(1, 8));
      endcase
      build_frame(n, $urandom_range(0, 3) != 0, q);
      if ($urandom_range(0, 1) == 1) q.push_front(8'($urandom_range(0, 8'hA4)));
      send_q(q, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0) ? 3 : 0);
      idle(int'($urandom_range(1, 3)));
    end

    // full-depth frame at one byte per cycle
    pulse_load();
    base = wr_cnt;
    build_frame(DEPTH, 1'b1, q);
    send_q(q, 0, 0);
    idle(2);
    chk32("full_writes", 32'(wr_cnt - base), 32'(DEPTH));
    chk32("full_last_addr", 32'(last_addr), 32'(DEPTH - 1));
    chk1("full_done", done, 1'b1);

    // synchronous reset in the middle of a frame
    pulse_load();
    base = wr_cnt;
    build_frame(4, 1'b1, q);
    for (int i = 0; i < 13; i++) send(q[i]);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    repeat (6) send(8'h00);
    chk32("midrst_writes", 32'(wr_cnt - base), 32'd2);
    chk1("midrst_busy", busy, 1'b1);
    chk1("midrst_core_rst_n", core_rst_n, 1'b0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
